// File: rtl/gpu_pkg.sv
// Shared definitions for the gpu core: default widths, opcode values and FSM state encoding.
package gpu_pkg;

  localparam int GPU_PC_W   = 10;
  localparam int GPU_ADDR_W = 20;
  localparam int GPU_DATA_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_LUI  = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_F1   = 3'd0,
    S_F2   = 3'd1,
    S_EX   = 3'd2,
    S_L1   = 3'd3,
    S_L2   = 3'd4,
    S_DONE = 3'd5,
    S_STOP = 3'd6
  } state_t;

endpackage

// File: rtl/gpu_alu.sv
// Combinational ALU for the gpu core; all results wrap modulo 2^DATA_W.
module gpu_alu
  import gpu_pkg::*;
#(
  parameter int DATA_W = GPU_DATA_W
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_LDI: o_y = i_b;
      OP_ADD: o_y = i_a + i_b;
      OP_SUB: o_y = i_a - i_b;
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_SHL: o_y = i_a << i_b[3:0];
      OP_SHR: o_y = i_a >> i_b[3:0];
      OP_MUL: o_y = i_a * i_b;
      // LUI replaces the high byte of the destination and keeps its low byte
      OP_LUI: begin
        o_y       = i_a;
        o_y[15:8] = i_b[7:0];
      end
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/gpu.sv
// Multi-cycle gpu core: fetch/execute FSM, pc, 16-entry register file and frame re-run control.
module gpu
  import gpu_pkg::*;
#(
  parameter int PC_W   = GPU_PC_W,
  parameter int ADDR_W = GPU_ADDR_W,
  parameter int DATA_W = GPU_DATA_W
) (
  input  logic              clk,
  input  logic              KEY0,
  input  logic              repeat_frame,
  input  logic              end_repeating,
  input  logic [DATA_W-1:0] data_input,
  output logic [ADDR_W-1:0] input_addr
);

  state_t            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_regs [16];
  logic [DATA_W-1:0] r_ir;
  logic [15:0]       r_frame_cnt, w_frame_nxt, w_frame_inc;

  logic [DATA_W-1:0] w_instr;
  logic [3:0]        w_op, w_rd, w_rs, w_rt, w_ra_addr, w_wa;
  logic [DATA_W-1:0] w_ra, w_rb, w_alu_b, w_alu_y, w_wd;
  logic              w_we;

  function automatic logic [PC_W-1:0] sext_pc(input logic [7:0] imm);
    return {{(PC_W-8){imm[7]}}, imm};
  endfunction

  // The instruction is live on data_input in EX; afterwards the latched copy drives the fields
  assign w_instr = (r_state == S_EX) ? data_input : r_ir;
  assign w_op    = w_instr[15:12];
  assign w_rd    = w_instr[11:8];
  assign w_rs    = w_instr[7:4];
  assign w_rt    = w_instr[3:0];

  assign w_ra_addr = ((r_state == S_EX) && ((w_op == OP_BEQZ) || (w_op == OP_LUI))) ? w_rd : w_rs;
  assign w_ra      = r_regs[w_ra_addr];
  assign w_rb      = r_regs[w_rt];
  assign w_alu_b   = ((w_op == OP_LDI) || (w_op == OP_LUI)) ? DATA_W'(w_instr[7:0]) : w_rb;
  assign w_frame_inc = r_frame_cnt + 16'd1;

  assign input_addr = ((r_state == S_L1) || (r_state == S_L2)) ? ADDR_W'(w_ra) : ADDR_W'(r_pc);

  gpu_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op (w_op),
    .i_a  (w_ra),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_frame_nxt = r_frame_cnt;
    w_we        = 1'b0;
    w_wa        = w_rd;
    w_wd        = w_alu_y;
    case (r_state)
      S_F1: w_state_nxt = S_F2;
      S_F2: w_state_nxt = S_EX;
      S_EX: begin
        w_state_nxt = S_F1;
        w_pc_nxt    = r_pc + PC_W'(1);
        case (w_op)
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_SHL, OP_SHR, OP_MUL, OP_LUI: w_we = 1'b1;
          OP_LD:   w_state_nxt = S_L1;
          OP_BEQZ: if (w_ra == '0) w_pc_nxt = r_pc + PC_W'(1) + sext_pc(w_instr[7:0]);
          OP_JMP:  w_pc_nxt = w_instr[PC_W-1:0];
          OP_HALT: begin
            w_state_nxt = S_DONE;
            w_pc_nxt    = r_pc;
          end
          default: ;
        endcase
      end
      S_L1: w_state_nxt = S_L2;
      S_L2: begin
        w_we        = 1'b1;
        w_wd        = data_input;
        w_state_nxt = S_F1;
      end
      S_DONE: begin
        // end_repeating has priority over a simultaneous repeat_frame
        if (end_repeating) begin
          w_state_nxt = S_STOP;
        end else if (repeat_frame) begin
          w_state_nxt = S_F1;
          w_pc_nxt    = '0;
          w_frame_nxt = w_frame_inc;
          w_we        = 1'b1;
          w_wa        = 4'd15;
          w_wd        = DATA_W'(w_frame_inc);
        end
      end
      S_STOP:  ;
      default: w_state_nxt = S_F1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (KEY0) begin
      r_state     <= S_F1;
      r_pc        <= '0;
      r_frame_cnt <= '0;
      r_ir        <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_frame_cnt <= w_frame_nxt;
      if (r_state == S_EX) r_ir <= data_input;
      if (w_we) r_regs[w_wa] <= w_wd;
    end
  end

endmodule

// File: tb/tb_gpu.sv
// Directed bench for gpu: table of ALU programs plus hand-written control-flow, load and frame sequences.
module tb_gpu;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        KEY0 = 1'b1;
  logic        repeat_frame = 1'b0;
  logic        end_repeating = 1'b0;
  logic [15:0] data_input;
  logic [19:0] input_addr;
  logic [15:0] mem [1024];

  int n_vec = 0;
  int n_err = 0;

  gpu dut (
    .clk           (clk),
    .KEY0          (KEY0),
    .repeat_frame  (repeat_frame),
    .end_repeating (end_repeating),
    .data_input    (data_input),
    .input_addr    (input_addr)
  );

  always #5 clk = ~clk;

  // Registered external memory
  always @(posedge clk) data_input <= mem[input_addr[9:0]];

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rrr(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [15:0] ri(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic clr_prog();
    for (int i = 0; i < 32; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    KEY0 = 1'b1;
    @(negedge clk);
    KEY0 = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int cyc);
    bit hit = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (dut.r_state == S_DONE) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("done_timeout", 32'(dut.r_state), 32'(S_DONE));
  endtask

  task automatic pulse(input bit rep, input bit endr);
    repeat_frame  = rep;
    end_repeating = endr;
    @(negedge clk);
    repeat_frame  = 1'b0;
    end_repeating = 1'b0;
  endtask

  initial begin
    int cyc;
    int cnt;
    bit seen;

    for (int i = 0; i < 1024; i++) mem[i] = 16'hF000;

    vecs[0]  = '{OP_ADD, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[1]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE};
    vecs[2]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030};
    vecs[3]  = '{OP_OR,  16'hF000, 16'h000F, 16'hF00F};
    vecs[4]  = '{OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555};
    vecs[5]  = '{OP_SHL, 16'h0001, 16'h000F, 16'h8000};
    vecs[6]  = '{OP_SHL, 16'h0003, 16'h0013, 16'h0018};
    vecs[7]  = '{OP_SHR, 16'h8000, 16'h000F, 16'h0001};
    vecs[8]  = '{OP_SHR, 16'hF000, 16'h0104, 16'h0F00};
    vecs[9]  = '{OP_MUL, 16'h1234, 16'h0010, 16'h2340};
    vecs[10] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[11] = '{OP_NOP, 16'h1111, 16'h2222, 16'h0000};
    vecs[12] = '{OP_RSV, 16'h1111, 16'h2222, 16'h0000};

    // ALU table: build both operands with LDI+LUI, apply op into R3, halt
    for (int v = 0; v < 13; v++) begin
      clr_prog();
      mem[0] = ri(OP_LDI, 4'd1, vecs[v].a[7:0]);
      mem[1] = ri(OP_LUI, 4'd1, vecs[v].a[15:8]);
      mem[2] = ri(OP_LDI, 4'd2, vecs[v].b[7:0]);
      mem[3] = ri(OP_LUI, 4'd2, vecs[v].b[15:8]);
      mem[4] = rrr(vecs[v].op, 4'd3, 4'd1, 4'd2);
      do_reset();
      run_to_done(100, cyc);
      chk($sformatf("alu_vec%0d", v), 32'(dut.r_regs[3]), 32'(vecs[v].y));
    end

    // Basic program, reset values and latency
    clr_prog();
    mem[0] = 16'h1105; mem[1] = 16'h1207; mem[2] = 16'h2312; mem[3] = 16'hF000;
    do_reset();
    chk("rst_pc", 32'(dut.r_pc), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(S_F1));
    chk("rst_r3", 32'(dut.r_regs[3]), 32'd0);
    chk("rst_addr", 32'(input_addr), 32'd0);
    run_to_done(100, cyc);
    chk("add_cycles", 32'(cyc), 32'd12);
    chk("add_r3", 32'(dut.r_regs[3]), 32'd12);
    chk("halt_pc", 32'(dut.r_pc), 32'd3);

    // LDI/LUI/LD with address hold count
    clr_prog();
    mem[0] = 16'h1134; mem[1] = 16'hD112; mem[2] = 16'h1464; mem[3] = 16'h9240;
    mem[100] = 16'hBEEF;
    do_reset();
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (input_addr == 20'd100) cnt++;
      if (dut.r_state == S_DONE) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ld_done", 32'(seen), 32'd1);
    chk("ld_r1", 32'(dut.r_regs[1]), 32'h1234);
    chk("ld_r2", 32'(dut.r_regs[2]), 32'hBEEF);
    chk("ld_addr_hold", 32'(cnt), 32'd2);

    // Countdown loop with BEQZ and JMP
    clr_prog();
    mem[0] = 16'h1103; mem[1] = 16'h1201; mem[2] = 16'h3112;
    mem[3] = 16'hB101; mem[4] = 16'hC002; mem[5] = 16'hF000;
    do_reset();
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dut.r_state == S_F1 && input_addr == 20'd2) cnt++;
      if (dut.r_state == S_DONE) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("loop_done", 32'(seen), 32'd1);
    chk("loop_r1", 32'(dut.r_regs[1]), 32'd0);
    chk("loop_iters", 32'(cnt), 32'd3);
    chk("loop_pc", 32'(dut.r_pc), 32'd5);

    // Frame repeats, pulses while running are dropped
    clr_prog();
    mem[0] = 16'h1109; mem[1] = 16'hF000;
    do_reset();
    run_to_done(100, cyc);
    for (int f = 0; f < 3; f++) begin
      pulse(1'b1, 1'b0);
      if (f == 2) pulse(1'b1, 1'b1);
      run_to_done(100, cyc);
    end
    chk("frame_cnt", 32'(dut.r_frame_cnt), 32'd3);
    chk("frame_r15", 32'(dut.r_regs[15]), 32'd3);
    chk("frame_r1_kept", 32'(dut.r_regs[1]), 32'd9);
    repeat (3) @(negedge clk);
    chk("frame_still_done", 32'(dut.r_state), 32'(S_DONE));

    // Simultaneous end/repeat in DONE -> STOP, then reset restarts
    pulse(1'b1, 1'b1);
    chk("stop_state", 32'(dut.r_state), 32'(S_STOP));
    chk("stop_frame", 32'(dut.r_frame_cnt), 32'd3);
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("stop_ignores", 32'(dut.r_state), 32'(S_STOP));
    chk("stop_addr", 32'(input_addr), 32'd1);
    do_reset();
    chk("rst2_pc", 32'(dut.r_pc), 32'd0);
    chk("rst2_frame", 32'(dut.r_frame_cnt), 32'd0);
    chk("rst2_r1", 32'(dut.r_regs[1]), 32'd0);
    chk("rst2_state", 32'(dut.r_state), 32'(S_F1));
    run_to_done(100, cyc);
    chk("rst2_r1_rerun", 32'(dut.r_regs[1]), 32'd9);

    // pc wrap: JMP 1023, NOP there, then fetch from 0 (changed to HALT meanwhile)
    clr_prog();
    mem[0] = 16'hC3FF;
    mem[1023] = 16'h0000;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (input_addr == 20'd1023) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wrap_reach_1023", 32'(seen), 32'd1);
    mem[0] = 16'hF000;
    run_to_done(100, cyc);
    chk("wrap_pc", 32'(dut.r_pc), 32'd0);
    chk("wrap_state", 32'(dut.r_state), 32'(S_DONE));

    // Reset landing in the middle of a load
    clr_prog();
    mem[0] = 16'h1464; mem[1] = 16'h9240; mem[2] = 16'hF000;
    mem[100] = 16'hCAFE;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dut.r_state == S_L1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("l1_reached", 32'(seen), 32'd1);
    KEY0 = 1'b1;
    @(negedge clk);
    KEY0 = 1'b0;
    chk("l1rst_state", 32'(dut.r_state), 32'(S_F1));
    chk("l1rst_pc", 32'(dut.r_pc), 32'd0);
    chk("l1rst_r4", 32'(dut.r_regs[4]), 32'd0);
    chk("l1rst_addr", 32'(input_addr), 32'd0);
    run_to_done(100, cyc);
    chk("l1rst_r2", 32'(dut.r_regs[2]), 32'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/gpu.md
GPU -- requirements
Module: gpu

Interface
REQ-001 The parameter list SHALL be PC_W, default 10, meaning program counter width (1024-word program space).
REQ-002 The parameter list SHALL include ADDR_W, default 20, meaning external address width.
REQ-003 The parameter list SHALL include DATA_W, default 16, meaning instruction and data word width.
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port KEY0  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-006 Port repeat_frame  input  1  is a one-cycle pulse requesting a re-run of the program.
REQ-007 Port end_repeating  input  1  is a one-cycle pulse that permanently stops re-runs until reset.
REQ-008 Port data_input  input  DATA_W  is the word returned by external memory.
REQ-009 Port input_addr  output  ADDR_W  is the external memory word address.

Function
REQ-010 External memory SHALL be treated as registered: data_input at edge n+2 is mem[input_addr held during cycle n+1], so the address SHALL be held for 2 cycles per access.
REQ-011 input_addr SHALL be combinational: {zeros, pc} in fetch states; {4'b0, R[rs]} in load states.
REQ-012 FSM states: F1, F2, EX, L1, L2, DONE, STOP; fetch flow F1->F2->EX; LD flow EX->L1->L2->F1 with R[rd]<=data_input captured at the end of L2; other instructions flow EX->F1.
REQ-013 The instruction SHALL be data_input sampled in EX; fields op[15:12], rd[11:8], rs[7:4], rt[3:0], imm8[7:0], imm12[11:0].
REQ-014 Register file: 16 x DATA_W registers R0..R15, two read ports and one write port.
REQ-015 Opcodes: 0 NOP; 1 LDI R[rd]=zext(imm8); 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR (R[rd]=R[rs] op R[rt]).
REQ-016 Opcodes: 7 SHL R[rd]=R[rs]<<R[rt][3:0]; 8 SHR logical; 9 LD R[rd]=mem[R[rs]]; A MUL R[rd]=low 16 bits of R[rs]*R[rt]; D LUI R[rd][15:8]=imm8 with the low byte kept.
REQ-017 Opcodes: B BEQZ, where if R[rd]==0 then pc=pc+1+sext(imm8), else pc+1; C JMP pc=imm12[PC_W-1:0]; E reserved and SHALL execute as NOP; F HALT.
REQ-018 Arithmetic SHALL be modulo 2^DATA_W with no flags; pc arithmetic SHALL be modulo 2^PC_W, so 1023+1 wraps to 0.
REQ-019 HALT SHALL move the FSM to DONE with pc unchanged.
REQ-020 In DONE, end_repeating=1 SHALL move the FSM to STOP; otherwise repeat_frame=1 SHALL set pc=0, increment frame_cnt, set R15<=frame_cnt+1, and go to F1.
REQ-021 If end_repeating and repeat_frame are asserted in the same cycle in DONE, end_repeating SHALL win.
REQ-022 repeat_frame and end_repeating SHALL be ignored (not latched) outside DONE; an end_repeating pulse given while running SHALL be lost.
REQ-023 In STOP the FSM SHALL ignore all inputs except KEY0; input_addr SHALL hold {zeros, pc}.
REQ-024 frame_cnt SHALL be a 16-bit wrapping counter; registers SHALL persist across frames except R15.

Reset
REQ-025 KEY0=1 at a clock edge SHALL set pc=0, all registers=0, frame_cnt=0, and state=F1, overriding any state including mid-instruction or mid-load.
REQ-026 After KEY0 is released, input_addr SHALL be 0 and the first fetch SHALL begin immediately; the first instruction executes in the 3rd cycle.

Structure
REQ-027 Opcode localparams, FSM state encoding, and the PC_W, ADDR_W and DATA_W defaults SHALL reside in shared package gpu_pkg.
REQ-028 The ALU SHALL be one combinational sub-module gpu_alu (op, a, b -> y); the FSM, pc and register file SHALL stay in gpu.

Verification
REQ-029 Reset then program {LDI R1,5; LDI R2,7; ADD R3,R1,R2; HALT} -> R3=12, state DONE, 12 cycles after reset release.
REQ-030 LDI R1,0x34; LUI R1,0x12; LDI R4,100; LD R2,R4 with mem[100]=0xBEEF -> R1=0x1234, R2=0xBEEF; input_addr=100 held for 2 cycles.
REQ-031 Loop {LDI R1,3; LDI R2,1; SUB R1,R1,R2; BEQZ R1,+1; JMP 2; HALT} -> HALT reached with R1=0 after 3 iterations.
REQ-032 Program halts, then 3 repeat_frame pulses each after DONE -> frame_cnt=3, R15=3; a pulse issued while running -> frame_cnt unchanged.
REQ-033 end_repeating and repeat_frame asserted together in DONE -> STOP, frame_cnt unchanged; later repeat_frame pulses are ignored; KEY0 pulse -> pc=0 and execution restarts.
REQ-034 JMP 1023 with mem[1023]=NOP and mem[0]=HALT -> pc wraps to 0 and the FSM reaches DONE; KEY0 asserted during L1 -> clean restart at pc 0.
